gemm_result_drain: RTL
======================

// Module: gemm_result_drain
// PURPOSE
//  Downstream of the tau-MAC GEMM array. Snapshots the DIM x DIM OUT_BITS result
//  matrix when the array signals completion. Requantizes each element to BITWIDTH
//  (logical right shift, then unsigned saturation). Streams the result out one row
//  per transfer over a valid/ready interface, freeing the array for the next GEMM.
// PARAMETERS
//  DIM       16           matrix dimension (rows, and elements per row)
//  BITWIDTH  8            output element width after requantization
//  OUT_BITS  2*BITWIDTH   width of each incoming accumulator element
//  SHW       $clog2(OUT_BITS)  width of shift control
// PORTS
//  clk          in   1                        clock; all logic on posedge
//  reset_n      in   1                        async active-low reset
//  res_in       in   [DIM][DIM][OUT_BITS]     result matrix from GEMM array, [row][col]
//  res_valid    in   1                        1-cycle pulse: res_in complete (array "finished")
//  shift        in   SHW                      requant right-shift, sampled with res_valid
//  out_row      out  [DIM][BITWIDTH]          requantized row, [col]
//  out_row_idx  out  $clog2(DIM)              index of row on out_row
//  out_valid    out  1                        out_row valid
//  out_ready    in   1                        consumer accepts when out_valid & out_ready
//  out_last     out  1                        out_valid on row DIM-1
//  busy         out  1                        buffer holds undrained data
//  overrun      out  1                        sticky: res_valid arrived while busy
//  clear_err    in   1                        synchronous clear of overrun
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, row counter 0, out_valid=0, out_last=0,
//   busy=0, overrun=0, out_row_idx=0, out_row=0, buffer and latched shift zeroed.
//  States: IDLE, DRAIN.
//  IDLE: res_valid=1 -> latch res_in and shift into buffer, row=0, go DRAIN.
//   Capture edge N -> out_valid=1 in cycle N+1 (one-cycle latency).
//  DRAIN: out_valid=1, busy=1, out_row_idx=row, out_row=requant(buffer[row]).
//   Handshake (out_valid & out_ready): row<DIM-1 -> row+1; row==DIM-1 -> IDLE.
//   out_row/out_row_idx held stable while out_valid & ~out_ready.
//   out_last = out_valid & (row==DIM-1).
//  Requant per element, unsigned: t = x >> shift_latched;
//   y = (t > 2^BITWIDTH-1) ? 2^BITWIDTH-1 : t[BITWIDTH-1:0]. Pure function of
//   registered buffer; no rounding.
//  Full-rate: with out_ready held high, DIM rows drain in DIM consecutive cycles.
//  Simultaneous: res_valid in the same cycle as the final (row DIM-1) handshake
//   -> accepted as a fresh capture; next cycle DRAIN row 0, no bubble, no overrun.
//  res_valid in DRAIN otherwise -> ignored (buffer, shift, row unchanged);
//   overrun<=1 and stays 1 until clear_err. clear_err and a new overrun in the
//   same cycle -> overrun=1 (set wins).
//  res_valid in IDLE -> no overrun.
//  busy = (state==DRAIN). res_in is don't-care except on the res_valid cycle.
//  Reset mid-drain: all state cleared immediately; partially drained data lost;
//   out_valid low from assertion.
// TESTING
//  1 Reset: assert reset_n=0 mid-DRAIN row 5 -> out_valid/busy/overrun=0 same
//    cycle; after release, IDLE with row 0.
//  2 Basic drain, DIM=4, shift=0, res_in[r][c]=r*4+c, out_ready=1 -> 4 rows on
//    cycles N+1..N+4, idx 0..3, values unchanged, out_last only on idx 3.
//  3 Requant/saturate, shift=4: element 0x0FF0->0xFF, 0x1000->0xFF (sat),
//    0x00A5->0x0A, 0x0000->0x00.
//  4 Backpressure: out_ready toggles 1,0,0,1 ... -> out_row and idx stable while
//    stalled; every row delivered exactly once, in order.
//  5 Overrun: res_valid at row 1 with different data -> stream keeps original data,
//    overrun=1 sticky; clear_err -> 0.
//  6 Back-to-back: res_valid coincident with row DIM-1 handshake -> next cycle
//    row 0 of new matrix, overrun stays 0.

Source files
------------

// File: rtl/gemm_result_drain.sv
// gemm_result_drain: snapshot GEMM result matrix, requantize, stream one row per handshake
//   clk, reset_n            clock, async active-low reset
//   res_in, res_valid       result matrix [row][col] and its one-cycle completion pulse
//   shift                   requant right shift, sampled with res_valid
//   out_row, out_row_idx    requantized row [col] and its row index
//   out_valid, out_ready    row stream handshake; out_last marks row DIM-1
//   busy, overrun           buffer holds undrained data; sticky dropped-capture flag
//   clear_err               synchronous clear of overrun (a same-cycle new overrun wins)
module gemm_result_drain #(
    parameter int DIM      = 16,
    parameter int BITWIDTH = 8,
    parameter int OUT_BITS = 2 * BITWIDTH,
    parameter int SHW      = $clog2(OUT_BITS),
    localparam int RW      = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0]   res_in,
    input  logic                                    res_valid,
    input  logic [SHW-1:0]                          shift,
    output logic [DIM-1:0][BITWIDTH-1:0]            out_row,
    output logic [RW-1:0]                           out_row_idx,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_last,
    output logic                                    busy,
    output logic                                    overrun,
    input  logic                                    clear_err
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t                                 state_q, state_d;
    logic [RW-1:0]                          row_q, row_d;
    logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0]  buf_q, buf_d;
    logic [SHW-1:0]                         shift_q, shift_d;
    logic                                   overrun_q, overrun_d;
    logic                                   hs, last_row, capture;
    assign busy        = (state_q == DRAIN);
    assign out_valid   = busy;
    assign out_row_idx = row_q;
    assign last_row    = (row_q == RW'(DIM - 1));
    assign out_last    = out_valid & last_row;
    assign overrun     = overrun_q;
    assign hs          = out_valid & out_ready;
    // A capture coinciding with the final handshake chains straight into the next drain
    assign capture     = res_valid & (~busy | (hs & last_row));
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        buf_d     = buf_q;
        shift_d   = shift_q;
        overrun_d = (res_valid & busy & ~capture) | (overrun_q & ~clear_err);
        if (capture) begin
            buf_d   = res_in;
            shift_d = shift;
            row_d   = '0;
            state_d = DRAIN;
        end else if (hs) begin
            row_d   = last_row ? '0 : row_q + RW'(1);
            state_d = last_row ? IDLE : DRAIN;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            buf_q     <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            buf_q     <= buf_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
        end
    end
    // Requantize straight from the registered buffer: shift, then saturate if any high bit survives
    for (genvar c = 0; c < DIM; c++) begin : g_col
        logic [OUT_BITS-1:0] t;
        assign t          = buf_q[row_q][c] >> shift_q;
        assign out_row[c] = !busy ? '0 : (|t[OUT_BITS-1:BITWIDTH]) ? {BITWIDTH{1'b1}} : t[BITWIDTH-1:0];
    end
endmodule
